vco_adc_capture_ctrl: RTL and testbench

Capture sequencer for the VCO-based ADC. Accepts start/stop commands and a burst configuration, drives the ADC enable and oversample inputs, and collects `data_valid_out` samples into a small first-word-fall-through FIFO. Software or a bus slave drains the FIFO through a valid/ready port. The block sits between the ADC and the user-area register interface, and reports completion, overflow and timeout status.

---
 rtl/vco_adc_capture_ctrl.sv | 159 +++++++++++++++
 tb/tb_vco_adc_capture_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vco_adc_capture_ctrl.sv
// Capture sequencer for the VCO-based ADC: runs start/stop bursts, gates the ADC
// enable, and buffers accepted samples in a small first-word-fall-through FIFO.
module vco_adc_capture_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic [CNT_W-1:0]      burst_len_in,
  input  logic [9:0]            oversample_cfg_in,
  input  logic [CNT_W-1:0]      timeout_in,
  output logic                  adc_enable_out,
  output logic [9:0]            adc_oversample_out,
  input  logic [DATA_WIDTH-1:0] adc_data_in,
  input  logic                  adc_valid_in,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  input  logic                  rd_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  overflow_out,
  output logic                  timeout_out,
  output logic [CNT_W-1:0]      count_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d, tmo_q, tmo_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d, count_q, count_d, count_inc;
  logic [9:0]       osr_q, osr_d;
  logic [1:0]       guard_q, guard_d;
  logic             ovf_q, ovf_d, tflag_q, tflag_d, done_q, done_d;
  logic             en_q, busy_q;

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  full, pop, push;

  assign rd_valid_out = (wr_ptr_q != rd_ptr_q);
  assign rd_data_out  = mem_q[rd_ptr_q[AW-1:0]];
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop          = rd_valid_out && rd_ready_in;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    tmo_d     = tmo_q;
    tcnt_d    = tcnt_q;
    count_d   = count_q;
    osr_d     = osr_q;
    guard_d   = guard_q;
    ovf_d     = ovf_q;
    tflag_d   = tflag_q;
    done_d    = 1'b0;
    push      = 1'b0;
    count_inc = count_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = RUN;
          burst_d = burst_len_in;
          tmo_d   = timeout_in;
          osr_d   = oversample_cfg_in;
          count_d = '0;
          ovf_d   = 1'b0;
          tflag_d = 1'b0;
          tcnt_d  = '0;
        end
      end
      RUN: begin
        tcnt_d = adc_valid_in ? '0 : ((tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_W'(1));
        if (adc_valid_in) begin
          if (!full || pop) begin
            push    = 1'b1;
            count_d = (count_q == '1) ? count_q : count_inc;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (push && (burst_q != '0) && (count_inc == burst_q)) state_d = STOP;
        if (stop_in) state_d = STOP;
        if ((tmo_q != '0) && (tcnt_q == tmo_q)) begin
          state_d = STOP;
          tflag_d = 1'b1;
        end
        if (state_d == STOP) guard_d = '0;
      end
      STOP: begin
        // Late ADC strobes are swallowed here while the guard window runs out.
        if (guard_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          guard_d = guard_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      tmo_q    <= '0;
      tcnt_q   <= '0;
      count_q  <= '0;
      osr_q    <= 10'h0FF;
      guard_q  <= '0;
      ovf_q    <= 1'b0;
      tflag_q  <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      tmo_q    <= tmo_d;
      tcnt_q   <= tcnt_d;
      count_q  <= count_d;
      osr_q    <= osr_d;
      guard_q  <= guard_d;
      ovf_q    <= ovf_d;
      tflag_q  <= tflag_d;
      done_q   <= done_d;
      en_q     <= (state_d == RUN);
      busy_q   <= (state_d != IDLE);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: sample storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= adc_data_in;
  end

  assign adc_enable_out     = en_q;
  assign adc_oversample_out = osr_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign overflow_out       = ovf_q;
  assign timeout_out        = tflag_q;
  assign count_out          = count_q;

endmodule

// File: tb/tb_vco_adc_capture_ctrl.sv
// Directed plus randomized bench for vco_adc_capture_ctrl against a queue-based
// behavioural model of the capture sequencer.
module tb_vco_adc_capture_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0, stop_in = 1'b0;
  logic [CW-1:0] burst_len_in = '0, timeout_in = '0;
  logic [9:0]    oversample_cfg_in = '0;
  logic          adc_enable_out;
  logic [9:0]    adc_oversample_out;
  logic [DW-1:0] adc_data_in = '0;
  logic          adc_valid_in = 1'b0;
  logic [DW-1:0] rd_data_out;
  logic          rd_valid_out;
  logic          rd_ready_in = 1'b0;
  logic          busy_out, done_out, overflow_out, timeout_out;
  logic [CW-1:0] count_out;

  always #5 clk = ~clk;

  vco_adc_capture_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in),
    .burst_len_in(burst_len_in), .oversample_cfg_in(oversample_cfg_in),
    .timeout_in(timeout_in), .adc_enable_out(adc_enable_out),
    .adc_oversample_out(adc_oversample_out), .adc_data_in(adc_data_in),
    .adc_valid_in(adc_valid_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in),
    .busy_out(busy_out), .done_out(done_out), .overflow_out(overflow_out),
    .timeout_out(timeout_out), .count_out(count_out)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 capturing, 2 draining the guard window.
  int            m_phase, m_age, m_count, m_tcnt, m_burst, m_tmo, m_osr;
  bit            m_ovf, m_tflag, m_done;
  logic [DW-1:0] m_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_count = 0; m_tcnt = 0;
    m_burst = 0; m_tmo = 0; m_osr = 'h0FF;
    m_ovf = 0; m_tflag = 0; m_done = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit st, input bit sp, input bit v,
                            input logic [DW-1:0] d, input bit rdy);
    bit popped, pushed, to_stop;
    popped  = rdy && (m_q.size() > 0);
    pushed  = 0;
    to_stop = 0;
    m_done  = 0;
    case (m_phase)
      0: if (st) begin
        m_phase = 1;
        m_burst = int'(burst_len_in);
        m_tmo   = int'(timeout_in);
        m_osr   = int'(oversample_cfg_in);
        m_count = 0; m_ovf = 0; m_tflag = 0; m_tcnt = 0;
      end
      1: begin
        if (v) begin
          if (m_q.size() < DEPTH || popped) begin
            pushed = 1;
            if (m_count < CMAX) m_count++;
            if (m_burst != 0 && m_count == m_burst) to_stop = 1;
          end else begin
            m_ovf = 1;
          end
        end
        if (sp) to_stop = 1;
        if (m_tmo != 0 && m_tcnt == m_tmo) begin
          to_stop = 1;
          m_tflag = 1;
        end
        m_tcnt = v ? 0 : ((m_tcnt < CMAX) ? m_tcnt + 1 : m_tcnt);
        if (to_stop) begin
          m_phase = 2;
          m_age   = 0;
        end
      end
      default: begin
        m_age++;
        if (m_age == 4) begin
          m_phase = 0;
          m_done  = 1;
        end
      end
    endcase
    if (popped) void'(m_q.pop_front());
    if (pushed) m_q.push_back(d);
  endtask

  task automatic compare_all();
    check("busy",       64'(busy_out),           64'(m_phase != 0));
    check("adc_enable", 64'(adc_enable_out),     64'(m_phase == 1));
    check("oversample", 64'(adc_oversample_out), 64'(m_osr));
    check("done",       64'(done_out),           64'(m_done));
    check("overflow",   64'(overflow_out),       64'(m_ovf));
    check("timeout",    64'(timeout_out),        64'(m_tflag));
    check("count",      64'(count_out),          64'(m_count));
    check("rd_valid",   64'(rd_valid_out),       64'(m_q.size() > 0));
    if (m_q.size() > 0) check("rd_data", 64'(rd_data_out), 64'(m_q[0]));
  endtask

  task automatic cycle(input bit st, input bit sp, input bit v,
                       input logic [DW-1:0] d, input bit rdy);
    start_in = st; stop_in = sp; adc_valid_in = v; adc_data_in = d; rd_ready_in = rdy;
    model_step(st, sp, v, d, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input int burst, input int tmo, input int osr);
    burst_len_in      = CW'(burst);
    timeout_in        = CW'(tmo);
    oversample_cfg_in = 10'(osr);
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, rdy);
  endtask

  task automatic wait_idle(input bit rdy);
    int n;
    n = 0;
    while (m_phase != 0 && n < 64) begin
      cycle(0, 0, 0, '0, rdy);
      n++;
    end
    check("idle_bound", 64'(m_phase), 64'(0));
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // Basic burst of three with the consumer always ready.
    set_cfg(3, 0, $urandom_range(0, 1023));
    cycle(1, 0, 0, '0, 1);
    cycle(0, 0, 1, 32'hA0, 1);
    cycle(0, 0, 1, 32'hA1, 1);
    cycle(0, 0, 1, 32'hA2, 1);
    idle_cycles(6, 1);

    // Continuous capture into a stalled FIFO: samples 5 and 6 are dropped.
    set_cfg(0, 0, $urandom_range(0, 1023));
    cycle(1, 0, 0, '0, 0);
    for (int i = 1; i <= 6; i++) cycle(0, 0, 1, DW'(i), 0);
    cycle(0, 1, 0, '0, 0);
    wait_idle(0);
    idle_cycles(5, 1);

    // Full FIFO with a simultaneous push and pop.
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, DW'(32'hB0 + i), 0);
    cycle(0, 0, 1, 32'hBF, 1);
    cycle(0, 1, 0, '0, 0);
    wait_idle(0);
    idle_cycles(5, 1);

    // Timeout with no samples, then a fresh start clears the sticky flag.
    set_cfg(0, 10, 'h155);
    cycle(1, 0, 0, '0, 1);
    idle_cycles(16, 1);
    wait_idle(1);
    set_cfg(0, 0, 'h2AA);
    cycle(1, 0, 0, '0, 1);
    cycle(0, 1, 0, '0, 1);
    wait_idle(1);

    // Stop together with a sample, start and sample during the guard window.
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 1, 32'hC0, 0);
    cycle(0, 1, 1, 32'hC1, 0);
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 1, 32'hC2, 0);
    wait_idle(0);
    idle_cycles(4, 1);

    // Randomized traffic with configurations changing underneath.
    for (int i = 0; i < 600; i++) begin
      set_cfg($urandom_range(0, 8),
              ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 12),
              $urandom_range(0, 1023));
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
    end
    wait_idle(1);

    // Asynchronous reset in the middle of a burst with two samples queued.
    set_cfg(0, 0, 'h3C3);
    cycle(1, 0, 0, '0, 0);
    cycle(0, 0, 1, 32'hD0, 0);
    cycle(0, 0, 1, 32'hD1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_rd_valid",   64'(rd_valid_out),       64'(0));
    check("rst_enable",     64'(adc_enable_out),     64'(0));
    check("rst_oversample", 64'(adc_oversample_out), 64'(10'h0FF));
    check("rst_busy",       64'(busy_out),           64'(0));
    #1;
    rst_n = 1'b1;
    idle_cycles(3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
